ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device transmit sequencer for the PS/2 keyboard port. It owns the open-drain pulldowns on ps2_clk and ps2_data.
- Arbitrates between two requesters:
  - the automatic keyboard reset, which sends 0xFF when 0xAA is received;
  - a general command port.
- Sequences the full protocol: clock inhibit, request-to-send, 8 data bits, odd parity, stop, device ACK, timeout.
- Sits beside the PS/2 receive deserializer. The receiver's 0xAA flag drives bat_seen.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles ps2_clk is held low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum clk cycles from clock release to ACK (15 ms at 50 MHz).
- CNT_WIDTH, 20: width of the shared cycle counter; must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- bat_seen  in  1  one-cycle pulse; 0xAA received, so a 0xFF send is requested.
- cmd_valid  in  1  general command request.
- cmd_data  in  8  command byte; sampled when cmd_valid && cmd_ready.
- cmd_ready  out  1  high only in IDLE with no pending auto-reset.
- ps2_clk_in  in  1  raw ps2_clk line (asynchronous).
- ps2_data_in  in  1  raw ps2_data line (asynchronous).
- ps2_clk_pulldown  out  1  1 = drive ps2_clk low.
- ps2_data_pulldown  out  1  1 = drive ps2_data low.
- busy  out  1  high in every state except IDLE.
- tx_done  out  1  one-cycle pulse; byte ACKed by the device.
- tx_err  out  1  one-cycle pulse; timeout or missing ACK.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE;
  - all outputs 0 except cmd_ready = 1 after release;
  - pending auto-reset flag cleared;
  - counter and synchronizers cleared (synchronizers to 1 = idle line).
- Input sync: ps2_clk_in and ps2_data_in each pass through 2 flops.
- Falling-edge detect: fall = prev & ~sync. The edge is visible 3 clk after the line falls.
- Arbitration:
  - A bat_seen pulse sets pending_rst in any state.
  - In IDLE, pending_rst wins over cmd_valid. pending_rst loads shift byte 0xFF and clears.
  - Otherwise a cmd handshake loads cmd_data.
  - A bat_seen arriving while busy is served after the current byte.
  - Multiple bat_seen pulses while busy collapse into one send.
- Parity: odd, computed at load. parity = ~^byte, so 0xFF gives 1 and 0x00 gives 1.
- State machine:
  - IDLE: load byte, set ps2_clk_pulldown = 1, counter = 0 -> INHIBIT.
  - INHIBIT:
    - count each cycle;
    - at count == INHIBIT_CYCLES-1, set ps2_data_pulldown = 1 and ps2_clk_pulldown = 0 (same cycle);
    - counter = 0, bit index = 0 -> SEND.
  - SEND:
    - on each fall, drive the next frame bit: pulldown = ~bit;
    - order: data bits 0..7 on falls 1-8, parity on fall 9, stop on fall 10 (stop = release data);
    - after fall 10 -> ACK.
  - ACK:
    - on the next fall, sample ps2_data sync;
    - 0: pulse tx_done -> RECOVER;
    - 1: pulse tx_err -> RECOVER.
  - RECOVER: wait until both synced lines are 1 -> IDLE.
- Timeout:
  - the counter runs from clock release through SEND, ACK and RECOVER;
  - at count == TIMEOUT_CYCLES-1, release both pulldowns, pulse tx_err (unless already pulsed this byte) -> IDLE;
  - byte dropped, pending_rst kept.
- tx_done and tx_err never assert in the same cycle. Each pulses at most once per byte.
- Both pulldowns are 0 in IDLE and RECOVER.
- ps2_data_pulldown is 1 only in INHIBIT's final cycle and in SEND.
- The two pulldowns are never both 1 outside INHIBIT's final cycle.
- A fall in IDLE or INHIBIT (device-initiated traffic) is ignored by this block. The receiver owns it.

Decomposition:
- Shared package ps2_pkg:
  - state encoding enum (IDLE, INHIBIT, SEND, ACK, RECOVER);
  - constants PS2_CMD_RESET = 8'hFF, PS2_BAT_OK = 8'hAA;
  - frame length 11.
- One sub-module ps2_line_sync: 2-flop synchronizer plus falling-edge detector. It is instantiated for ps2_clk (edge used) and ps2_data (level only).
- The existing generic counter may serve as the cycle counter.

Test Plan:
- Auto-reset: pulse bat_seen; device model clocks 11 falls at 12 kHz and ACKs low. Required:
  - ps2_clk_pulldown high for exactly 5000 cycles;
  - data frame on falls 1-10 = 1,1,1,1,1,1,1,1, parity 1, stop 1 (data pulldown 0 throughout);
  - tx_done one pulse;
  - busy drops after lines idle.
- Command 0xED with cmd_valid in IDLE. Required:
  - cmd_ready drops the next cycle;
  - data pulldown on falls 1-8 = ~(1,0,1,1,0,1,1,1) (LSB first);
  - parity 1;
  - tx_done pulses.
- Priority: bat_seen and cmd_valid (0x00) in the same IDLE cycle. Required:
  - 0xFF sent first;
  - cmd_ready stays 0 until 0xFF completes;
  - 0x00 then sent with parity 1.
- No ACK: device leaves data high on fall 11. Required: tx_err one pulse, no tx_done, return to IDLE.
- Timeout: device never clocks after release. Required:
  - at cycle 750000 after release, both pulldowns 0 and tx_err pulses;
  - with TIMEOUT_CYCLES = 1000 overridden, at 1000.
- Reset mid-SEND after fall 4: assert rst low. Required: both pulldowns 0 immediately (asynchronous), busy 0, pending_rst cleared, no tx_done or tx_err.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 host-transmit definitions: FSM state encoding, protocol bytes, frame helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_SEND    = 3'd2,
    ST_ACK     = 3'd3,
    ST_RECOVER = 3'd4
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_RESET = 8'hFF;  // keyboard reset command
  localparam logic [7:0] PS2_BAT_OK    = 8'hAA;  // self-test passed, reported by the receiver
  localparam int         PS2_FRAME_LEN = 11;     // start, 8 data, parity, stop

  // Bits the host drives after falls 1..10, LSB first: data[7:0], odd parity, stop.
  function automatic logic [9:0] ps2_tx_bits(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Handshake/line bundle between the PS/2 host transmitter and its neighbours.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready; bat_seen is a fire-and-forget pulse.
// Ports: bat_seen, cmd_valid, cmd_data[7:0] -> in; cmd_ready, busy, tx_done, tx_err -> out;
//        ps2_clk_in/ps2_data_in raw lines -> in; ps2_clk_pulldown/ps2_data_pulldown -> out.
interface ps2_host_tx_if;

  logic       bat_seen;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_pulldown;
  logic       ps2_data_pulldown;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  // Requester / board side
  modport master (
    output bat_seen, cmd_valid, cmd_data, ps2_clk_in, ps2_data_in,
    input  cmd_ready, ps2_clk_pulldown, ps2_data_pulldown, busy, tx_done, tx_err
  );

  // Transmitter side
  modport slave (
    input  bat_seen, cmd_valid, cmd_data, ps2_clk_in, ps2_data_in,
    output cmd_ready, ps2_clk_pulldown, ps2_data_pulldown, busy, tx_done, tx_err
  );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus a registered falling-edge detector.
// Latency: o_sync follows i_line after 2 clk; o_fall is high in the 3rd clk after the line falls.
// Backpressure: none; free-running.
// Ports: i_clk, i_rst_n (async active-low), i_line (async), o_sync (level), o_fall (1-cycle pulse).
module ps2_line_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_sync,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Reset to 1: an idle open-drain line floats high, so no false edge after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 8 data + odd parity + stop, ACK, timeout.
// Latency: INHIBIT_CYCLES of clock inhibit, then paced by device clock falls; result pulse on fall 11.
// Backpressure: cmd_ready only in IDLE with no pending auto-reset; bat_seen requests collapse into one 0xFF send.
// Ports: clk, rst (async active-low), bus (ps2_host_tx_if.slave: command port, bat_seen, raw lines,
//        open-drain pulldowns, busy/tx_done/tx_err status).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int CNT_WIDTH      = 20
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] LP_INH_LAST = CNT_WIDTH'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LP_TMO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]           LP_STOP_IDX = 4'(PS2_FRAME_LEN - 2);  // fall index of the stop bit

  ps2_state_e           r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]           r_bit_idx, w_bit_idx_nxt;
  logic [9:0]           r_frame, w_frame_nxt;
  logic                 r_data_pd, w_data_pd_nxt;
  logic                 r_reported, w_reported_nxt;
  logic                 r_pending_rst;

  logic w_clk_sync, w_clk_fall;
  logic w_data_sync, w_data_fall_unused;
  logic w_rst_req, w_load_rst, w_timeout, w_tx_done, w_tx_err;

  ps2_line_sync u_clk_sync (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_line  (bus.ps2_clk_in),
    .o_sync  (w_clk_sync),
    .o_fall  (w_clk_fall)
  );

  // Data line is only ever sampled as a level (ACK and idle check).
  ps2_line_sync u_data_sync (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_line  (bus.ps2_data_in),
    .o_sync  (w_data_sync),
    .o_fall  (w_data_fall_unused)
  );

  // A bat_seen in the same cycle as a command still wins, so treat it as already pending.
  assign w_rst_req = r_pending_rst | bus.bat_seen;

  // Counter keeps running from clock release until the byte finishes; one shared timeout.
  assign w_timeout = ((r_state == ST_SEND) || (r_state == ST_ACK) || (r_state == ST_RECOVER))
                     && (r_cnt == LP_TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_bit_idx     <= '0;
      r_frame       <= '0;
      r_data_pd     <= 1'b0;
      r_reported    <= 1'b0;
      r_pending_rst <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_bit_idx     <= w_bit_idx_nxt;
      r_frame       <= w_frame_nxt;
      r_data_pd     <= w_data_pd_nxt;
      r_reported    <= w_reported_nxt;
      r_pending_rst <= (r_pending_rst | bus.bat_seen) & ~w_load_rst;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_frame_nxt    = r_frame;
    w_data_pd_nxt  = r_data_pd;
    w_reported_nxt = r_reported;
    w_load_rst     = 1'b0;
    w_tx_done      = 1'b0;
    w_tx_err       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_data_pd_nxt = 1'b0;
        if (w_rst_req || bus.cmd_valid) begin
          w_frame_nxt    = w_rst_req ? ps2_tx_bits(PS2_CMD_RESET) : ps2_tx_bits(bus.cmd_data);
          w_load_rst     = w_rst_req;
          w_cnt_nxt      = '0;
          w_reported_nxt = 1'b0;
          w_state_nxt    = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (r_cnt == LP_INH_LAST) begin
          // Start bit (data low) is held from here until the first fall.
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
          w_data_pd_nxt = 1'b1;
          w_state_nxt   = ST_SEND;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_SEND, ST_ACK, ST_RECOVER: begin
        if (w_timeout) begin
          // Byte is dropped; a pending auto-reset survives and is served from IDLE.
          w_tx_err       = ~r_reported;
          w_reported_nxt = 1'b1;
          w_data_pd_nxt  = 1'b0;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          case (r_state)
            ST_SEND: begin
              if (w_clk_fall) begin
                w_data_pd_nxt = ~r_frame[0];
                w_frame_nxt   = {1'b1, r_frame[9:1]};
                w_bit_idx_nxt = r_bit_idx + 4'd1;
                if (r_bit_idx == LP_STOP_IDX) begin
                  w_state_nxt = ST_ACK;
                end
              end
            end
            ST_ACK: begin
              if (w_clk_fall) begin
                w_tx_done      = ~w_data_sync;
                w_tx_err       = w_data_sync;
                w_reported_nxt = 1'b1;
                w_state_nxt    = ST_RECOVER;
              end
            end
            ST_RECOVER: begin
              if (w_clk_sync && w_data_sync) begin
                w_state_nxt = ST_IDLE;
              end
            end
            default: begin
              w_state_nxt = ST_IDLE;
            end
          endcase
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready         = (r_state == ST_IDLE) && !w_rst_req;
  assign bus.busy              = (r_state != ST_IDLE);
  assign bus.ps2_clk_pulldown  = (r_state == ST_INHIBIT);
  // Data goes low one cycle before clock release so the device sees request-to-send cleanly.
  assign bus.ps2_data_pulldown = ((r_state == ST_INHIBIT) && (r_cnt == LP_INH_LAST))
                                 || ((r_state == ST_SEND) && r_data_pd && !w_timeout);
  assign bus.tx_done           = w_tx_done;
  assign bus.tx_err            = w_tx_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain line model and a PS/2 device model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_ps2_host_tx;

  localparam int INH  = 5000;
  localparam int TMO  = 1000;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic rst;
  logic dev_clk;
  logic dev_data;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  int n_err    = 0;
  int n_both   = 0;
  int n_hs     = 0;
  int run      = 0;
  int last_run = 0;

  ps2_host_tx_if ifc ();

  // Open-drain wired-AND of device drive and host pulldown.
  assign ifc.ps2_clk_in  = dev_clk  & ~ifc.ps2_clk_pulldown;
  assign ifc.ps2_data_in = dev_data & ~ifc.ps2_data_pulldown;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .CNT_WIDTH      (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // Observation counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (ifc.ps2_clk_pulldown) run++;
    else begin
      if (run != 0) last_run = run;
      run = 0;
    end
    if (ifc.tx_done) n_done++;
    if (ifc.tx_err) n_err++;
    if (ifc.ps2_clk_pulldown && ifc.ps2_data_pulldown) n_both++;
    if (ifc.cmd_valid && ifc.cmd_ready) n_hs++;
  end

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // Reference frame: LSB-first data, parity making the count of ones odd, stop high.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b};
  endfunction

  // Device side of one host-to-device byte: wait for request-to-send, clock 11 falls,
  // record the data line before each rising edge, optionally ACK on fall 11.
  task automatic dev_byte(input bit ack, output logic [9:0] bits);
    int t;
    t = 0;
    bits = '0;
    while (!(ifc.busy && ifc.ps2_data_pulldown && !ifc.ps2_clk_pulldown) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t >= 20000) $display("FAIL rts_seen: request-to-send not seen within %0d cycles", t);
    else begin
      n_pass++;
      for (int k = 1; k <= 11; k++) begin
        if (k == 11 && ack) dev_data = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        if (k <= 10) bits[k-1] = ifc.ps2_data_in;
        dev_clk = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_idle(output int t);
    t = 0;
    while (ifc.busy && t < 200) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    int t;
    t = 0;
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_data  = b;
    @(negedge clk);
    while (!ifc.cmd_ready && t < 30000) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ifc.cmd_ready !== 1'b0 || t >= 30000)
      $display("FAIL cmd_ready_drop: cmd_ready=%b wait=%0d, required 0 after handshake", ifc.cmd_ready, t);
    else n_pass++;
  endtask

  task automatic pulse_bat();
    @(posedge clk); #1;
    ifc.bat_seen = 1'b1;
    @(posedge clk); #1;
    ifc.bat_seen = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    ifc.bat_seen = 1'b0;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_data = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ifc.ps2_clk_pulldown, ifc.ps2_data_pulldown, ifc.busy} !== 3'b000)
      $display("FAIL reset_in: pd/busy=%b, required 000", {ifc.ps2_clk_pulldown, ifc.ps2_data_pulldown, ifc.busy});
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ifc.cmd_ready, ifc.busy, ifc.tx_done, ifc.tx_err} !== 4'b1000)
      $display("FAIL reset_out: ready/busy/done/err=%b, required 1000",
               {ifc.cmd_ready, ifc.busy, ifc.tx_done, ifc.tx_err});
    else n_pass++;
    n_checks++;
    if ({ifc.ps2_clk_pulldown, ifc.ps2_data_pulldown} !== 2'b00)
      $display("FAIL reset_pd: pulldowns=%b, required 00", {ifc.ps2_clk_pulldown, ifc.ps2_data_pulldown});
    else n_pass++;
  endtask

  task automatic test_auto_reset();
    int d0, e0, b0, t;
    logic [9:0] bits;
    d0 = n_done; e0 = n_err; b0 = n_both;
    pulse_bat();
    @(negedge clk);
    n_checks++;
    if (ifc.busy !== 1'b1) $display("FAIL auto_busy: busy=%b, required 1", ifc.busy);
    else n_pass++;
    dev_byte(1'b1, bits);
    n_checks++;
    if (last_run !== INH) $display("FAIL inhibit_len: clk pulldown %0d cycles, required %0d", last_run, INH);
    else n_pass++;
    n_checks++;
    if (bits !== frame_of(8'hFF)) $display("FAIL auto_frame: got %b, required %b", bits, frame_of(8'hFF));
    else n_pass++;
    wait_idle(t);
    n_checks++;
    if (ifc.busy !== 1'b0) $display("FAIL auto_idle: busy=%b, required 0", ifc.busy);
    else n_pass++;
    n_checks++;
    if ((n_done - d0) != 1 || (n_err - e0) != 0)
      $display("FAIL auto_result: done=%0d err=%0d, required 1 0", n_done - d0, n_err - e0);
    else n_pass++;
    n_checks++;
    if ((n_both - b0) != 1) $display("FAIL both_pd: both pulldowns high %0d cycles, required 1", n_both - b0);
    else n_pass++;
  endtask

  task automatic test_cmd_ed();
    int d0, t;
    logic [9:0] bits;
    d0 = n_done;
    send_cmd(8'hED);
    dev_byte(1'b1, bits);
    n_checks++;
    if (bits !== 10'b11_1110_1101) $display("FAIL cmd_ed_frame: got %b, required 1111101101", bits);
    else n_pass++;
    wait_idle(t);
    n_checks++;
    if ((n_done - d0) != 1 || ifc.busy !== 1'b0)
      $display("FAIL cmd_ed_done: done=%0d busy=%b, required 1 0", n_done - d0, ifc.busy);
    else n_pass++;
  endtask

  task automatic test_priority();
    int hs0, d0, t;
    logic [9:0] bits;
    hs0 = n_hs; d0 = n_done;
    @(posedge clk); #1;
    ifc.bat_seen = 1'b1;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_data = 8'h00;
    @(posedge clk); #1;
    ifc.bat_seen = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ifc.cmd_ready, ifc.busy} !== 2'b01)
      $display("FAIL prio_start: ready/busy=%b, required 01", {ifc.cmd_ready, ifc.busy});
    else n_pass++;
    dev_byte(1'b1, bits);
    n_checks++;
    if (bits !== frame_of(8'hFF)) $display("FAIL prio_first: got %b, required %b", bits, frame_of(8'hFF));
    else n_pass++;
    n_checks++;
    if ((n_hs - hs0) != 0) $display("FAIL prio_hold: %0d handshakes during 0xFF, required 0", n_hs - hs0);
    else n_pass++;
    t = 0;
    while (!ifc.ps2_clk_pulldown && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0;
    n_checks++;
    if ((n_hs - hs0) != 1) $display("FAIL prio_accept: %0d handshakes, required 1", n_hs - hs0);
    else n_pass++;
    dev_byte(1'b1, bits);
    n_checks++;
    if (bits !== frame_of(8'h00)) $display("FAIL prio_second: got %b, required %b", bits, frame_of(8'h00));
    else n_pass++;
    wait_idle(t);
    n_checks++;
    if ((n_done - d0) != 2) $display("FAIL prio_done: done=%0d, required 2", n_done - d0);
    else n_pass++;
  endtask

  task automatic test_random();
    int d0, e0, t;
    logic [7:0] b;
    bit ack;
    logic [9:0] bits;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      ack = 1'($urandom_range(0, 1));
      d0 = n_done; e0 = n_err;
      send_cmd(b);
      dev_byte(ack, bits);
      n_checks++;
      if (bits !== frame_of(b)) $display("FAIL rand_frame: byte %h got %b, required %b", b, bits, frame_of(b));
      else n_pass++;
      wait_idle(t);
      n_checks++;
      if ((n_done - d0) != int'(ack) || (n_err - e0) != int'(!ack) || ifc.busy !== 1'b0)
        $display("FAIL rand_result: ack=%0d done=%0d err=%0d busy=%b, required %0d %0d 0",
                 ack, n_done - d0, n_err - e0, ifc.busy, ack, !ack);
      else n_pass++;
    end
  endtask

  task automatic test_no_ack();
    int d0, e0, t;
    logic [9:0] bits;
    d0 = n_done; e0 = n_err;
    send_cmd(8'h5A);
    dev_byte(1'b0, bits);
    wait_idle(t);
    n_checks++;
    if ((n_done - d0) != 0 || (n_err - e0) != 1)
      $display("FAIL no_ack: done=%0d err=%0d, required 0 1", n_done - d0, n_err - e0);
    else n_pass++;
    n_checks++;
    if (ifc.busy !== 1'b0) $display("FAIL no_ack_idle: busy=%b, required 0", ifc.busy);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int e0, c, t;
    logic [1:0] pd;
    send_cmd(8'($urandom_range(0, 255)));
    t = 0;
    while (!(ifc.busy && !ifc.ps2_clk_pulldown) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    e0 = n_err;
    c = 1;
    while (!ifc.tx_err && c < TMO + 50) begin
      @(negedge clk);
      c++;
    end
    pd = {ifc.ps2_clk_pulldown, ifc.ps2_data_pulldown};
    n_checks++;
    if (c != TMO) $display("FAIL timeout_cycle: tx_err at cycle %0d after release, required %0d", c, TMO);
    else n_pass++;
    n_checks++;
    if (pd !== 2'b00) $display("FAIL timeout_pd: pulldowns=%b, required 00", pd);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (ifc.busy !== 1'b0 || (n_err - e0) != 1)
      $display("FAIL timeout_idle: busy=%b err=%0d, required 0 1", ifc.busy, n_err - e0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_send();
    int d0, e0, t;
    d0 = n_done; e0 = n_err;
    send_cmd(8'($urandom_range(0, 255)));
    t = 0;
    while (!(ifc.busy && !ifc.ps2_clk_pulldown) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    for (int k = 1; k <= 4; k++) begin
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      if (k < 4) begin
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
      end
    end
    repeat (5) @(negedge clk);
    pulse_bat();
    @(negedge clk);
    n_checks++;
    if ({ifc.busy, ifc.ps2_clk_pulldown} !== 2'b10)
      $display("FAIL mid_send_state: busy/clk_pd=%b, required 10", {ifc.busy, ifc.ps2_clk_pulldown});
    else n_pass++;
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({ifc.ps2_clk_pulldown, ifc.ps2_data_pulldown, ifc.busy} !== 3'b000)
      $display("FAIL async_reset: pd/busy=%b, required 000",
               {ifc.ps2_clk_pulldown, ifc.ps2_data_pulldown, ifc.busy});
    else n_pass++;
    @(negedge clk);
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if ({ifc.busy, ifc.cmd_ready} !== 2'b01)
      $display("FAIL pending_cleared: busy/ready=%b, required 01", {ifc.busy, ifc.cmd_ready});
    else n_pass++;
    n_checks++;
    if ((n_done - d0) != 0 || (n_err - e0) != 0)
      $display("FAIL reset_no_result: done=%0d err=%0d, required 0 0", n_done - d0, n_err - e0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d0, t;
    logic [7:0] b;
    logic [7:0] exp_q[$];
    logic [9:0] bits;
    d0 = n_done;
    b = 8'($urandom_range(0, 255));
    send_cmd(b);
    exp_q.push_back(b);
    // Several auto-reset requests while busy collapse into a single 0xFF.
    for (int i = 0; i < 3; i++) begin
      pulse_bat();
      repeat (7) @(negedge clk);
    end
    exp_q.push_back(8'hFF);
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      dev_byte(1'b1, bits);
      n_checks++;
      if (bits !== frame_of(b)) $display("FAIL b2b_frame: byte %h got %b, required %b", b, bits, frame_of(b));
      else n_pass++;
    end
    wait_idle(t);
    repeat (20) @(negedge clk);
    n_checks++;
    if ({ifc.busy, ifc.cmd_ready} !== 2'b01)
      $display("FAIL b2b_collapse: busy/ready=%b, required 01", {ifc.busy, ifc.cmd_ready});
    else n_pass++;
    n_checks++;
    if ((n_done - d0) != 2) $display("FAIL b2b_done: done=%0d, required 2", n_done - d0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_auto_reset();
    test_cmd_ed();
    test_priority();
    test_random();
    test_no_ack();
    test_timeout();
    test_reset_mid_send();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
